// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline stage with valid/ready flow control and a two-entry skid buffer.
// Suppresses rd==x0 writes, selects the writeback data and counts output stall cycles.
module wb_pipe_stage #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_write,
  input  logic             in_mem_to_reg,
  input  logic [RD_W-1:0]  in_rd,
  input  logic [XLEN-1:0]  in_result,
  input  logic [XLEN-1:0]  in_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_reg_write,
  output logic             out_mem_to_reg,
  output logic [RD_W-1:0]  out_rd,
  output logic [XLEN-1:0]  out_wb_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // The state encoding doubles as the occupancy count; main is valid in ONE/TWO, skid only in TWO.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rdata;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept;
  logic             pop;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    in_entry.reg_write  = in_reg_write && (in_rd != '0);
    in_entry.mem_to_reg = in_mem_to_reg;
    in_entry.rd         = in_rd;
    in_entry.result     = in_result;
    in_entry.rdata      = in_rdata;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = in_entry;
        end else if (accept) begin
          skid_d  = in_entry;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over any simultaneous accept or pop; payload left behind is don't-care.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign out_reg_write  = out_valid && main_q.reg_write;
  assign out_mem_to_reg = main_q.mem_to_reg;
  assign out_rd         = main_q.rd;
  assign out_wb_data    = main_q.mem_to_reg ? main_q.rdata : main_q.result;
  assign occupancy      = state_q;
  assign stall_cnt      = stall_q;

endmodule
